// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-cycle sequencer and the decoder side.
// Contents: FSM state enum, phase-class enum, opcode field position, named opcodes.
// No logic here; the opcode helper is a pure field extract.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_E1,
    S_E2,
    S_E3,
    S_HALT
  } state_t;

  // Number of execute phases an opcode needs; CLS_STOP marks the halt opcode.
  typedef enum logic [1:0] {
    CLS_STOP,
    CLS_1,
    CLS_2,
    CLS_3
  } phase_cls_t;

  localparam int INSTR_W = 16;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 11;

  localparam logic [4:0] OP_STP = 5'b00000;
  localparam logic [4:0] OP_ADM = 5'b00010;
  localparam logic [4:0] OP_MLR = 5'b00111;
  localparam logic [4:0] OP_LDI = 5'b10001;

  function automatic logic [4:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Bundle between the sequencer and its neighbours (instruction memory, decoder, run control).
// master: the sequencer (drives ir, phase strobes, status, retired count).
// slave : the environment (drives run, instr_q, mem_wait, and step when PHASE_SEQ_STEP_EN is defined).
interface phase_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             run;
  logic [15:0]      instr_q;
  logic             mem_wait;
`ifdef PHASE_SEQ_STEP_EN
  logic             step;
`endif
  logic [15:0]      ir;
  logic             f;
  logic             e1;
  logic             e2;
  logic             e3;
  logic             busy;
  logic             halted;
  logic [CNT_W-1:0] retired;

`ifdef PHASE_SEQ_STEP_EN
  modport master (
    input  run, instr_q, mem_wait, step,
    output ir, f, e1, e2, e3, busy, halted, retired
  );
  modport slave (
    output run, instr_q, mem_wait, step,
    input  ir, f, e1, e2, e3, busy, halted, retired
  );
`else
  modport master (
    input  run, instr_q, mem_wait,
    output ir, f, e1, e2, e3, busy, halted, retired
  );
  modport slave (
    output run, instr_q, mem_wait,
    input  ir, f, e1, e2, e3, busy, halted, retired
  );
`endif

endinterface

// File: rtl/op_class.sv
// Combinational opcode -> execute-phase-class lookup.
// Ports: opcode (instr[15:11]) in, cls out. No state, zero latency.
// Shared with decoder-side checks so both agree on instruction length.
module op_class
  import cpu_pkg::*;
(
  input  logic [4:0] opcode,
  output phase_cls_t cls
);

  always_comb begin
    cls = CLS_STOP;
    casez (opcode)
      OP_STP:   cls = CLS_STOP;
      5'b00001: cls = CLS_1;
      5'b00010: cls = CLS_2;
      5'b00011: cls = CLS_2;
      5'b00100: cls = CLS_1;
      5'b00101: cls = CLS_2;
      5'b00110: cls = CLS_2;
      5'b00111: cls = CLS_3;
      5'b01000: cls = CLS_3;
      5'b01001: cls = CLS_1;
      5'b01010: cls = CLS_1;
      5'b01011: cls = CLS_1;
      5'b0110?: cls = CLS_1;
      5'b01110: cls = CLS_1;
      5'b01111: cls = CLS_1;
      5'b100??: cls = CLS_1;
      5'b101??: cls = CLS_2;
      5'b11000: cls = CLS_2;
      5'b11001: cls = CLS_2;
      5'b11010: cls = CLS_3;
      5'b11011: cls = CLS_3;
      5'b111??: cls = CLS_2;
      default:  cls = CLS_STOP;
    endcase
  end

endmodule

// File: rtl/phase_sequencer.sv
// Instruction-cycle FSM: FETCH, DECODE, then 1..3 execute phases; owns ir and the retired count.
// Ports: clk, rst_n (async active-low, already release-synchronised upstream), bus (master modport).
// Latency run->f 1 cycle; mem_wait stretches E2 only. Optional PHASE_SEQ_STEP_EN adds single-step.
module phase_sequencer
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  phase_sequencer_if.master   bus
);

  state_t           state_q;
  state_t           state_d;
  phase_cls_t       cls_q;
  phase_cls_t       dec_cls;
  logic [15:0]      ir_q;
  logic [CNT_W-1:0] retired_q;
  logic             f_q;
  logic             e1_q;
  logic             e2_q;
  logic             e3_q;
  logic             busy_q;
  logic             halted_q;
  logic             retire;
  logic             start;
  logic             cont;

  op_class u_op_class (
    .opcode (opcode_of(bus.instr_q)),
    .cls    (dec_cls)
  );

`ifdef PHASE_SEQ_STEP_EN
  // Set when the current instruction was launched by step rather than run;
  // forces a return to IDLE at its end whatever run does meanwhile.
  logic step_mode_q;
  assign start = bus.run | bus.step;
  assign cont  = bus.run & ~step_mode_q;
`else
  assign start = bus.run;
  assign cont  = bus.run;
`endif

  // run is only looked at in IDLE and at end-of-instruction, so dropping it
  // mid-instruction lets the instruction finish.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = (dec_cls == CLS_STOP) ? S_HALT : S_E1;
      S_E1: begin
        if (cls_q == CLS_2 || cls_q == CLS_3) state_d = S_E2;
        else                                  retire  = 1'b1;
      end
      S_E2: begin
        if (!bus.mem_wait) begin
          if (cls_q == CLS_3) state_d = S_E3;
          else                retire  = 1'b1;
        end
      end
      S_E3:     retire  = 1'b1;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
    if (retire) state_d = cont ? S_FETCH : S_IDLE;
  end

  // Strobes and status are decoded from the next state so they come straight
  // from flops yet line up with the registered state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cls_q     <= CLS_STOP;
      ir_q      <= '0;
      retired_q <= '0;
      f_q       <= 1'b0;
      e1_q      <= 1'b0;
      e2_q      <= 1'b0;
      e3_q      <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
`ifdef PHASE_SEQ_STEP_EN
      step_mode_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      f_q      <= (state_d == S_FETCH);
      e1_q     <= (state_d == S_E1);
      e2_q     <= (state_d == S_E2);
      e3_q     <= (state_d == S_E3);
      busy_q   <= (state_d != S_IDLE) && (state_d != S_HALT);
      halted_q <= (state_d == S_HALT);
      // Class is captured alongside ir so later phases never re-decode ir.
      if (state_q == S_DECODE) begin
        ir_q  <= bus.instr_q;
        cls_q <= dec_cls;
      end
      if (retire) retired_q <= retired_q + CNT_W'(1);
`ifdef PHASE_SEQ_STEP_EN
      if (state_q == S_IDLE && state_d == S_FETCH) step_mode_q <= ~bus.run;
      else if (retire)                             step_mode_q <= 1'b0;
`endif
    end
  end

  assign bus.ir      = ir_q;
  assign bus.f       = f_q;
  assign bus.e1      = e1_q;
  assign bus.e2      = e2_q;
  assign bus.e3      = e3_q;
  assign bus.busy    = busy_q;
  assign bus.halted  = halted_q;
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer: issue() queues program entries and the
// expected strobe records; a monitor pops one record per strobe cycle and compares
// phase, ir, retired and fetch spacing. A driver feeds instr_q and mem_wait.
module tb_phase_sequencer;
  import cpu_pkg::*;

  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  phase_sequencer_if #(.CNT_W(CNT_W)) bus ();

  phase_sequencer #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int               ph;    // 0=f 1=e1 2=e2 3=e3
    logic [15:0]      ir;
    logic [CNT_W-1:0] ret;
    int               gap;   // cycles since previous f (f records only, 0 = unchecked)
  } exp_t;

  typedef struct {
    logic [15:0] instr;
    int          waits;
    bit          drop;
  } prog_t;

  exp_t  sb_q[$];
  prog_t prog_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int last_f_cyc = 0;

  logic [15:0]      m_ir;
  logic [CNT_W-1:0] m_ret;

  int    cur_waits = 0;
  int    e2_run    = 0;
  bit    cur_drop  = 0;
  prog_t drv_p;

  int    mon_n;
  int    mon_ph;
  exp_t  mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_f"},       32'(bus.f), 32'd0);
    check({tag, "_e1"},      32'(bus.e1), 32'd0);
    check({tag, "_e2"},      32'(bus.e2), 32'd0);
    check({tag, "_e3"},      32'(bus.e3), 32'd0);
    check({tag, "_busy"},    32'(bus.busy), 32'd0);
    check({tag, "_halted"},  32'(bus.halted), 32'd0);
    check({tag, "_ir"},      32'(bus.ir), 32'd0);
    check({tag, "_retired"}, 32'(bus.retired), 32'd0);
  endtask

  // Asserts reset mid-cycle (no clock edge) and checks the outputs fall at once.
  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    bus.run = 1'b0;
    bus.mem_wait = 1'b0;
    sb_q.delete();
    prog_q.delete();
    m_ir = '0;
    m_ret = '0;
    cur_waits = 0;
    cur_drop = 0;
    #1;
    check_reset(tag);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // cls: hand-derived phase class (0 = stp). gap: hand-computed cycles since previous f.
  task automatic issue(input logic [15:0] instr, input int cls, input int waits,
                       input bit drop, input int gap);
    prog_t p;
    exp_t  e;
    p.instr = instr; p.waits = waits; p.drop = drop;
    prog_q.push_back(p);
    e.ph = 0; e.ir = m_ir; e.ret = m_ret; e.gap = gap;
    sb_q.push_back(e);
    m_ir = instr;
    if (cls > 0) begin
      e.ir = instr; e.gap = 0;
      e.ph = 1; sb_q.push_back(e);
      if (cls >= 2) begin
        e.ph = 2;
        for (int i = 0; i <= waits; i++) sb_q.push_back(e);
      end
      if (cls == 3) begin
        e.ph = 3; sb_q.push_back(e);
      end
      m_ret = m_ret + 1'b1;
    end
  endtask

  // Returns 1 time unit after the negedge at which the last expected strobe was popped.
  task automatic wait_drain(input int limit, input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < limit) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: timeout with %0d expected strobes outstanding", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Driver: hands the next instruction to memory during f, holds mem_wait in E2.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.f && prog_q.size() > 0) begin
        drv_p = prog_q.pop_front();
        bus.instr_q = drv_p.instr;
        cur_waits = drv_p.waits;
        cur_drop = drv_p.drop;
      end
      if (bus.e2) begin
        bus.mem_wait = (e2_run < cur_waits);
        e2_run++;
        if (cur_drop) bus.run = 1'b0;
      end else begin
        bus.mem_wait = 1'b0;
        e2_run = 0;
      end
    end
  end

  // Monitor: every strobe cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      mon_n = int'(bus.f) + int'(bus.e1) + int'(bus.e2) + int'(bus.e3);
      mon_ph = bus.e1 ? 1 : bus.e2 ? 2 : bus.e3 ? 3 : 0;
      if (mon_n > 1) begin
        n_tests++;
        n_fail++;
        $display("FAIL one_hot: %0d strobes high, expected at most 1", mon_n);
      end else if (mon_n == 1) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_strobe: phase %0d high, no strobe expected", mon_ph);
        end else begin
          mon_e = sb_q.pop_front();
          check("phase", 32'(mon_ph), 32'(mon_e.ph));
          check("ir", 32'(bus.ir), 32'(mon_e.ir));
          check("retired", 32'(bus.retired), 32'(mon_e.ret));
          if (mon_ph == 0) begin
            if (mon_e.gap > 0) check("f_gap", 32'(cyc - last_f_cyc), 32'(mon_e.gap));
            last_f_cyc = cyc;
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    bus.run = 1'b0;
    bus.instr_q = 16'h0000;
    bus.mem_wait = 1'b0;
`ifdef PHASE_SEQ_STEP_EN
    bus.step = 1'b0;
`endif
    #1;
    apply_reset("por");

    // ldi (1-phase), adm (2-phase, 3 waits), mlr (3-phase), then 0x2800 with run dropped in E2.
    issue(16'h8805, 1, 0, 0, 0);
    issue(16'h1000, 2, 3, 0, 3);
    issue(16'h3800, 3, 0, 0, 7);
    issue(16'h2800, 2, 0, 1, 5);
    bus.run = 1'b1;
    @(negedge clk);
    #1;
    check("run_to_f", 32'(bus.f), 32'd1);
    wait_drain(100, "chain");
    @(negedge clk);
    #1;
    check("drop_busy", 32'(bus.busy), 32'd0);
    check("drop_halted", 32'(bus.halted), 32'd0);
    check("drop_retired", 32'(bus.retired), 32'd4);
    check("drop_ir", 32'(bus.ir), 32'h2800);
    repeat (4) @(negedge clk);
    #1;
    check("idle_busy", 32'(bus.busy), 32'd0);

    // stp: fetch, decode, halt; run toggling must not restart it.
    issue(16'h0000, 0, 0, 0, 0);
    bus.run = 1'b1;
    wait_drain(20, "stp");
    @(negedge clk);
    #1;
    check("decode_busy", 32'(bus.busy), 32'd1);
    check("decode_phases", 32'({bus.f, bus.e1, bus.e2, bus.e3}), 32'd0);
    @(negedge clk);
    #1;
    check("halt_halted", 32'(bus.halted), 32'd1);
    check("halt_busy", 32'(bus.busy), 32'd0);
    check("halt_retired", 32'(bus.retired), 32'd4);
    check("halt_ir", 32'(bus.ir), 32'h0000);
    for (int i = 0; i < 6; i++) begin
      bus.run = (i % 2 == 0);
      @(negedge clk);
      #1;
    end
    check("halt_stays", 32'(bus.halted), 32'd1);
    check("halt_count", 32'(bus.retired), 32'd4);

    apply_reset("halt_rst");

    // Fill the counter to all-ones, then reset in the middle of the next E1.
    for (int i = 0; i < (1 << CNT_W) - 1; i++) issue(16'h8805, 1, 0, 0, (i == 0) ? 0 : 3);
    bus.run = 1'b1;
    wait_drain(3000, "fill");
    bus.run = 1'b0;
    @(negedge clk);
    #1;
    check("fill_retired", 32'(bus.retired), 32'hFF);
    check("fill_busy", 32'(bus.busy), 32'd0);
    issue(16'h8805, 1, 0, 0, 0);
    bus.run = 1'b1;
    wait_drain(20, "pre_rst");
    check("pre_rst_e1", 32'(bus.e1), 32'd1);
    apply_reset("mid_e1");

    // 2^CNT_W completions from zero wrap the counter back to zero.
    for (int i = 0; i < (1 << CNT_W); i++) issue(16'h8805, 1, 0, 0, (i == 0) ? 0 : 3);
    bus.run = 1'b1;
    wait_drain(3000, "wrap");
    bus.run = 1'b0;
    @(negedge clk);
    #1;
    check("wrap_retired", 32'(bus.retired), 32'd0);
    check("wrap_busy", 32'(bus.busy), 32'd0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
